// File: rtl/rob_core.sv
// rob_core -- in-order-retire reorder buffer.
//
// Takes one instruction per cycle in program order and hands back its slot
// index as the tag. Results arrive on two writeback channels (wb0 = ALU,
// wb1 = LSB/branch, wb1 carries branch mispredict info). The head entry
// retires once its result is in, at most one per cycle. A mispredicted
// branch retiring at the head flushes the whole buffer and redirects fetch.
//
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (global stall)
//   alloc_*      : allocation request, ready and assigned tag
//   wb0_*, wb1_* : result writeback channels
//   query_*      : combinational operand lookup with writeback bypass
//   commit_*     : registered one-cycle retire pulse and retired entry
//   flush_*      : registered one-cycle flush pulse and redirect PC
//   count_out, full_out, empty_out : occupancy, from registered state only

// One ROB slot. The top decides which slot is allocated/committed/flushed;
// the slot only has to qualify writeback hits against its own busy bit.
module rob_entry #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            alloc_en_i,
    input  logic            commit_en_i,
    input  logic            flush_en_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            wb0_hit_i,
    input  logic [XLEN-1:0] wb0_value_i,
    input  logic            wb1_hit_i,
    input  logic [XLEN-1:0] wb1_value_i,
    input  logic            wb1_mis_i,
    input  logic [XLEN-1:0] wb1_tgt_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] value_o,
    output logic            mis_o,
    output logic [XLEN-1:0] tgt_o
);
    logic            busy_q, done_q, mis_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q, value_q, tgt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            pc_q    <= '0;
            value_q <= '0;
            tgt_q   <= '0;
        end else if (flush_en_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mis_q  <= 1'b0;
        end else if (alloc_en_i) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            rd_q   <= rd_i;
            pc_q   <= pc_i;
        end else if (commit_en_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (busy_q && (wb0_hit_i || wb1_hit_i)) begin
            done_q <= 1'b1;
            // wb1 wins when both channels name the same slot
            if (wb1_hit_i) begin
                value_q <= wb1_value_i;
                mis_q   <= wb1_mis_i;
                tgt_q   <= wb1_tgt_i;
            end else begin
                value_q <= wb0_value_i;
            end
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign rd_o    = rd_q;
    assign pc_o    = pc_q;
    assign value_o = value_q;
    assign mis_o   = mis_q;
    assign tgt_o   = tgt_q;
endmodule

module rob_core #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4,
    parameter int XLEN      = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             alloc_valid_in,
    input  logic [4:0]       alloc_rd_in,
    input  logic [XLEN-1:0]  alloc_pc_in,
    output logic             alloc_ready_out,
    output logic [TAG_W-1:0] alloc_tag_out,
    input  logic             wb0_valid_in,
    input  logic [TAG_W-1:0] wb0_tag_in,
    input  logic [XLEN-1:0]  wb0_value_in,
    input  logic             wb1_valid_in,
    input  logic [TAG_W-1:0] wb1_tag_in,
    input  logic [XLEN-1:0]  wb1_value_in,
    input  logic             wb1_mispredict_in,
    input  logic [XLEN-1:0]  wb1_target_in,
    input  logic [TAG_W-1:0] query_tag_in,
    output logic             query_ready_out,
    output logic [XLEN-1:0]  query_value_out,
    output logic             commit_valid_out,
    output logic [4:0]       commit_rd_out,
    output logic [XLEN-1:0]  commit_value_out,
    output logic [TAG_W-1:0] commit_tag_out,
    output logic             flush_out,
    output logic [XLEN-1:0]  flush_pc_out,
    output logic [TAG_W:0]   count_out,
    output logic             full_out,
    output logic             empty_out
);
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             cvalid_q, cvalid_d, flush_q, flush_d;
    logic [4:0]       crd_q, crd_d;
    logic [XLEN-1:0]  cvalue_q, cvalue_d, fpc_q, fpc_d;
    logic [TAG_W-1:0] ctag_q, ctag_d;

    logic [ROB_DEPTH-1:0]           busy_w, done_w, mis_w;
    logic [ROB_DEPTH-1:0][4:0]      rd_w;
    logic [ROB_DEPTH-1:0][XLEN-1:0] pc_w, value_w, tgt_w;

    logic full_w, do_commit, do_flush, do_alloc;

    assign full_w    = (count_q == DEPTH_C);
    // Full is judged on pre-edge state: a commit this cycle does not make room.
    assign do_commit = rdy_in && busy_w[head_q] && done_w[head_q];
    assign do_flush  = do_commit && mis_w[head_q];
    assign do_alloc  = rdy_in && alloc_valid_in && !full_w && !do_flush;

    for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent
        rob_entry #(.XLEN(XLEN)) u_ent (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .alloc_en_i  (do_alloc && (tail_q == TAG_W'(i))),
            .commit_en_i (do_commit && (head_q == TAG_W'(i))),
            .flush_en_i  (do_flush),
            .rd_i        (alloc_rd_in),
            .pc_i        (alloc_pc_in),
            .wb0_hit_i   (rdy_in && wb0_valid_in && (wb0_tag_in == TAG_W'(i))),
            .wb0_value_i (wb0_value_in),
            .wb1_hit_i   (rdy_in && wb1_valid_in && (wb1_tag_in == TAG_W'(i))),
            .wb1_value_i (wb1_value_in),
            .wb1_mis_i   (wb1_mispredict_in),
            .wb1_tgt_i   (wb1_target_in),
            .busy_o      (busy_w[i]),
            .done_o      (done_w[i]),
            .rd_o        (rd_w[i]),
            .pc_o        (pc_w[i]),
            .value_o     (value_w[i]),
            .mis_o       (mis_w[i]),
            .tgt_o       (tgt_w[i])
        );
    end

    // PC is kept per slot for trace/debug visibility; nothing in the datapath reads it.
    logic unused_pc;
    assign unused_pc = ^pc_w;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        cvalid_d = 1'b0;
        flush_d  = 1'b0;
        crd_d    = crd_q;
        cvalue_d = cvalue_q;
        ctag_d   = ctag_q;
        fpc_d    = fpc_q;
        if (do_commit) begin
            cvalid_d = 1'b1;
            crd_d    = rd_w[head_q];
            cvalue_d = value_w[head_q];
            ctag_d   = head_q;
        end
        if (do_flush) begin
            flush_d = 1'b1;
            fpc_d   = tgt_w[head_q];
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_commit) head_d = head_q + TAG_W'(1);
            if (do_alloc)  tail_d = tail_q + TAG_W'(1);
            count_d = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cvalid_q <= 1'b0;
            flush_q  <= 1'b0;
            crd_q    <= '0;
            cvalue_q <= '0;
            ctag_q   <= '0;
            fpc_q    <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cvalid_q <= cvalid_d;
            flush_q  <= flush_d;
            crd_q    <= crd_d;
            cvalue_q <= cvalue_d;
            ctag_q   <= ctag_d;
            fpc_q    <= fpc_d;
        end
    end

    // Operand lookup: same-cycle writeback bypasses the stored value.
    always_comb begin
        query_ready_out = 1'b0;
        query_value_out = '0;
        if (busy_w[query_tag_in]) begin
            if (wb1_valid_in && wb1_tag_in == query_tag_in) begin
                query_ready_out = 1'b1;
                query_value_out = wb1_value_in;
            end else if (wb0_valid_in && wb0_tag_in == query_tag_in) begin
                query_ready_out = 1'b1;
                query_value_out = wb0_value_in;
            end else begin
                query_ready_out = done_w[query_tag_in];
                query_value_out = value_w[query_tag_in];
            end
        end
    end

    assign alloc_ready_out  = !full_w;
    assign alloc_tag_out    = tail_q;
    assign commit_valid_out = cvalid_q;
    assign commit_rd_out    = crd_q;
    assign commit_value_out = cvalue_q;
    assign commit_tag_out   = ctag_q;
    assign flush_out        = flush_q;
    assign flush_pc_out     = fpc_q;
    assign count_out        = count_q;
    assign full_out         = full_w;
    assign empty_out        = (count_q == '0);
endmodule

// File: tb/tb_rob_core.sv
module tb_rob_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic [31:0] alloc_pc = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        wb0_valid = 1'b0;
    logic [3:0]  wb0_tag = '0;
    logic [31:0] wb0_value = '0;
    logic        wb1_valid = 1'b0;
    logic [3:0]  wb1_tag = '0;
    logic [31:0] wb1_value = '0;
    logic        wb1_mis = 1'b0;
    logic [31:0] wb1_target = '0;
    logic [3:0]  query_tag = '0;
    logic        query_ready;
    logic [31:0] query_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_tag;
    logic        flush;
    logic [31:0] flush_pc;
    logic [4:0]  count;
    logic        full, empty;

    int n_checks = 0;
    int n_fails  = 0;

    rob_core #(.ROB_DEPTH(16), .TAG_W(4), .XLEN(32)) dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .rdy_in            (rdy),
        .alloc_valid_in    (alloc_valid),
        .alloc_rd_in       (alloc_rd),
        .alloc_pc_in       (alloc_pc),
        .alloc_ready_out   (alloc_ready),
        .alloc_tag_out     (alloc_tag),
        .wb0_valid_in      (wb0_valid),
        .wb0_tag_in        (wb0_tag),
        .wb0_value_in      (wb0_value),
        .wb1_valid_in      (wb1_valid),
        .wb1_tag_in        (wb1_tag),
        .wb1_value_in      (wb1_value),
        .wb1_mispredict_in (wb1_mis),
        .wb1_target_in     (wb1_target),
        .query_tag_in      (query_tag),
        .query_ready_out   (query_ready),
        .query_value_out   (query_value),
        .commit_valid_out  (commit_valid),
        .commit_rd_out     (commit_rd),
        .commit_value_out  (commit_value),
        .commit_tag_out    (commit_tag),
        .flush_out         (flush),
        .flush_pc_out      (flush_pc),
        .count_out         (count),
        .full_out          (full),
        .empty_out         (empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        wb1_mis = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic [3:0] exp_tag);
        alloc_valid = 1'b1;
        alloc_rd = rd;
        alloc_pc = 32'h100 + {27'd0, rd} * 4;
        #1;
        check_eq("alloc_tag", alloc_tag, exp_tag);
        check_eq("alloc_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state, checked while reset is asserted.
        #2;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_alloc_tag", alloc_tag, 0);
        check_eq("rst_commit", commit_valid, 0);
        check_eq("rst_flush", flush, 0);
        tick();
        rst_n = 1'b1;

        // Three allocations, then out-of-order writeback and in-order retire.
        for (int i = 0; i < 3; i++) alloc_one(5'(i + 1), 4'(i));
        check_eq("count3", count, 3);
        wb0_valid = 1'b1;
        wb0_tag = 4'd2; wb0_value = 32'h30; tick();
        wb0_tag = 4'd1; wb0_value = 32'h20; tick();
        wb0_tag = 4'd0; wb0_value = 32'h10; tick();
        wb0_valid = 1'b0;
        check_eq("no_early_commit", commit_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("inord_valid", commit_valid, 1);
            check_eq("inord_tag", commit_tag, 4'(i));
            check_eq("inord_rd", commit_rd, 5'(i + 1));
            check_eq("inord_value", commit_value, 32'h10 * (i + 1));
            check_eq("inord_count", count, 5'(2 - i));
        end
        tick();
        check_eq("drain_valid", commit_valid, 0);
        check_eq("drain_empty", empty, 1);

        // Fill all 16 entries, refuse the 17th, wrap the tail after one retire.
        do_reset();
        for (int i = 0; i < 16; i++) alloc_one(5'(i + 1), 4'(i));
        check_eq("full", full, 1);
        check_eq("full_ready", alloc_ready, 0);
        check_eq("full_count", count, 16);
        alloc_valid = 1'b1;
        alloc_rd = 5'd17;
        tick();
        check_eq("17th_count", count, 16);
        wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_value = 32'h55;
        tick();
        wb0_valid = 1'b0;
        check_eq("full_done_count", count, 16);
        tick();   // commit happens; full was true before the edge so alloc refused
        check_eq("fc_commit", commit_valid, 1);
        check_eq("fc_tag", commit_tag, 0);
        check_eq("fc_value", commit_value, 32'h55);
        check_eq("fc_count", count, 15);
        check_eq("fc_ready", alloc_ready, 1);
        check_eq("wrap_tag", alloc_tag, 0);
        tick();
        alloc_valid = 1'b0;
        check_eq("refill_count", count, 16);
        check_eq("refill_commit", commit_valid, 0);

        // Dual writeback to the same tag: wb1 wins, query bypasses.
        wb0_valid = 1'b1; wb0_tag = 4'd5; wb0_value = 32'hAA;
        wb1_valid = 1'b1; wb1_tag = 4'd5; wb1_value = 32'hBB;
        query_tag = 4'd5;
        #1;
        check_eq("bypass_ready", query_ready, 1);
        check_eq("bypass_value", query_value, 32'hBB);
        tick();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        #1;
        check_eq("stored_ready", query_ready, 1);
        check_eq("stored_value", query_value, 32'hBB);
        query_tag = 4'd6;
        #1;
        check_eq("notdone_ready", query_ready, 0);
        wb0_valid = 1'b1; wb0_tag = 4'd6; wb0_value = 32'h66;
        #1;
        check_eq("wb0_bypass", query_value, 32'h66);
        wb0_valid = 1'b0;

        // Mispredict at tag1 flushes; tags 2 and 3 never retire.
        do_reset();
        query_tag = 4'd3;
        #1;
        check_eq("nonbusy_query", query_ready, 0);
        for (int i = 0; i < 4; i++) alloc_one(5'(i + 1), 4'(i));
        wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_value = 32'h10;
        wb1_valid = 1'b1; wb1_tag = 4'd1; wb1_value = 32'h11;
        wb1_mis = 1'b1; wb1_target = 32'h1000;
        tick();
        wb1_valid = 1'b0; wb1_mis = 1'b0;
        wb0_tag = 4'd2; wb0_value = 32'h12;
        tick();
        check_eq("pre_flush_commit", commit_valid, 1);
        check_eq("pre_flush_tag", commit_tag, 0);
        check_eq("pre_flush_flush", flush, 0);
        check_eq("pre_flush_count", count, 3);
        wb0_tag = 4'd3; wb0_value = 32'h13;
        tick();
        wb0_valid = 1'b0;
        check_eq("flush_commit", commit_valid, 1);
        check_eq("flush_tag", commit_tag, 1);
        check_eq("flush_value", commit_value, 32'h11);
        check_eq("flush_pulse", flush, 1);
        check_eq("flush_pc", flush_pc, 32'h1000);
        check_eq("flush_count", count, 0);
        check_eq("flush_empty", empty, 1);
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        #1;
        check_eq("post_flush_tag", alloc_tag, 0);
        check_eq("post_flush_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        check_eq("post_flush_count", count, 1);
        check_eq("flush_one_cycle", flush, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("no_stale_commit", commit_valid, 0);
        end

        // Stall while the head is done; then alloc+commit together.
        do_reset();
        alloc_one(5'd7, 4'd0);
        wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_value = 32'h42;
        tick();
        wb0_valid = 1'b0;
        rdy = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_commit", commit_valid, 0);
            check_eq("stall_count", count, 1);
        end
        check_eq("stall_tag", alloc_tag, 1);
        rdy = 1'b1;
        tick();
        alloc_valid = 1'b0;
        check_eq("resume_commit", commit_valid, 1);
        check_eq("resume_value", commit_value, 32'h42);
        check_eq("resume_rd", commit_rd, 7);
        check_eq("alloc_commit_count", count, 1);
        tick();
        check_eq("resume_one_cycle", commit_valid, 0);

        // Asynchronous reset with a retire pending.
        wb0_valid = 1'b1; wb0_tag = 4'd1; wb0_value = 32'h99;
        tick();
        wb0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", count, 0);
        check_eq("arst_empty", empty, 1);
        check_eq("arst_tag", alloc_tag, 0);
        tick();
        check_eq("arst_commit", commit_valid, 0);
        check_eq("arst_flush", flush, 0);
        rst_n = 1'b1;
        tick();
        check_eq("arst_after_commit", commit_valid, 0);
        check_eq("arst_after_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
